median_window: RTL and testbench

MEDIAN_WINDOW -- requirements
Module: median_window

---
 rtl/median_pkg.sv | 15 +
 rtl/median_window_if.sv | 27 ++
 rtl/median_window.sv | 171 +++++++++++++++++
 tb/tb_median_window.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the median filter path: the default sample width
// and the window-former state encoding.
package median_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        PRIME2 = 3'd2,
        RUN    = 3'd3,
        FLUSH  = 3'd4
    } state_t;

endpackage

// File: rtl/median_window_if.sv
// Sample stream in and 3-sample window stream out of the window former.
// The slave modport is the window former's view; master is the
// environment driving samples and accepting windows.
interface median_window_if #(
    parameter int DW = median_pkg::DW_DEFAULT
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] a0;
    logic [DW-1:0] a1;
    logic [DW-1:0] a2;
    logic          win_valid;
    logic          win_last;
    logic          win_ready;

    modport master (
        output in_data, in_valid, in_last, win_ready,
        input  in_ready, a0, a1, a2, win_valid, win_last
    );

    modport slave (
        input  in_data, in_valid, in_last, win_ready,
        output in_ready, a0, a1, a2, win_valid, win_last
    );
endinterface

// File: rtl/median_window.sv
// Forms 3-sample sliding windows (oldest, middle, newest) from a framed
// sample stream for the downstream median stage. With EDGE_REPLICATE set,
// the first and last samples of a frame are replicated so every input
// sample yields one window; otherwise only windows of three real samples
// are produced. The output is a single registered slot with backpressure.
module median_window #(
    parameter int DW             = median_pkg::DW_DEFAULT,
    parameter int EDGE_REPLICATE = 1
) (
    input logic           clk,
    input logic           rst,
    median_window_if.slave bus
);
    import median_pkg::*;

    localparam bit REP = (EDGE_REPLICATE != 0);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [DW-1:0] w_old_r;
    logic [DW-1:0] w_mid_r;
    logic [DW-1:0] w_new_r;
    logic [DW-1:0] w_old_nxt_s;
    logic [DW-1:0] w_mid_nxt_s;
    logic [DW-1:0] w_new_nxt_s;
    logic [DW-1:0] a0_r;
    logic [DW-1:0] a1_r;
    logic [DW-1:0] a2_r;
    logic [DW-1:0] a0_nxt_s;
    logic [DW-1:0] a1_nxt_s;
    logic [DW-1:0] a2_nxt_s;
    logic          win_valid_r;
    logic          win_last_r;
    logic          win_valid_nxt_s;
    logic          win_last_nxt_s;
    logic          slot_free_s;
    logic          in_ready_s;
    logic          in_xfer_s;

    // Slot can take a new window when empty or being drained this cycle;
    // no sample is accepted in reset or while the flush window is pending.
    always_comb begin
        slot_free_s = !win_valid_r || bus.win_ready;
        in_ready_s  = !rst && (state_r != FLUSH) && slot_free_s;
        in_xfer_s   = bus.in_valid && in_ready_s;
    end

    // Next-state, window shift and output slot logic.
    always_comb begin
        state_nxt_s     = state_r;
        a0_nxt_s        = a0_r;
        a1_nxt_s        = a1_r;
        a2_nxt_s        = a2_r;
        win_valid_nxt_s = win_valid_r && !bus.win_ready;
        win_last_nxt_s  = win_last_r && !bus.win_ready;

        if (in_xfer_s) begin
            w_old_nxt_s = w_mid_r;
            w_mid_nxt_s = w_new_r;
            w_new_nxt_s = bus.in_data;
        end else begin
            w_old_nxt_s = w_old_r;
            w_mid_nxt_s = w_mid_r;
            w_new_nxt_s = w_new_r;
        end

        case (state_r)
            IDLE: begin
                if (in_xfer_s && REP) begin
                    // first sample fills the whole window (left-edge replication)
                    w_old_nxt_s = bus.in_data;
                    w_mid_nxt_s = bus.in_data;
                    if (bus.in_last) begin
                        a0_nxt_s        = bus.in_data;
                        a1_nxt_s        = bus.in_data;
                        a2_nxt_s        = bus.in_data;
                        win_valid_nxt_s = 1'b1;
                        win_last_nxt_s  = 1'b1;
                        state_nxt_s     = IDLE;
                    end else begin
                        state_nxt_s = PRIME;
                    end
                end else if (in_xfer_s) begin
                    state_nxt_s = bus.in_last ? IDLE : PRIME;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRIME: begin
                if (in_xfer_s && REP) begin
                    a0_nxt_s        = w_old_r;
                    a1_nxt_s        = w_mid_r;
                    a2_nxt_s        = bus.in_data;
                    win_valid_nxt_s = 1'b1;
                    win_last_nxt_s  = 1'b0;
                    state_nxt_s     = bus.in_last ? FLUSH : RUN;
                end else if (in_xfer_s) begin
                    // a two-sample frame has no full window: drop it
                    state_nxt_s = bus.in_last ? IDLE : PRIME2;
                end else begin
                    state_nxt_s = PRIME;
                end
            end
            PRIME2, RUN: begin
                if (in_xfer_s) begin
                    a0_nxt_s        = w_mid_r;
                    a1_nxt_s        = w_new_r;
                    a2_nxt_s        = bus.in_data;
                    win_valid_nxt_s = 1'b1;
                    win_last_nxt_s  = bus.in_last && !REP;
                    if (bus.in_last) begin
                        state_nxt_s = REP ? FLUSH : IDLE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            FLUSH: begin
                if (slot_free_s) begin
                    // right-edge replication of the final sample
                    a0_nxt_s        = w_mid_r;
                    a1_nxt_s        = w_new_r;
                    a2_nxt_s        = w_new_r;
                    win_valid_nxt_s = 1'b1;
                    win_last_nxt_s  = 1'b1;
                    state_nxt_s     = IDLE;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, window and output slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            w_old_r     <= {DW{1'b0}};
            w_mid_r     <= {DW{1'b0}};
            w_new_r     <= {DW{1'b0}};
            a0_r        <= {DW{1'b0}};
            a1_r        <= {DW{1'b0}};
            a2_r        <= {DW{1'b0}};
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            w_old_r     <= w_old_nxt_s;
            w_mid_r     <= w_mid_nxt_s;
            w_new_r     <= w_new_nxt_s;
            a0_r        <= a0_nxt_s;
            a1_r        <= a1_nxt_s;
            a2_r        <= a2_nxt_s;
            win_valid_r <= win_valid_nxt_s;
            win_last_r  <= win_last_nxt_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.a0        = a0_r;
    assign bus.a1        = a1_r;
    assign bus.a2        = a2_r;
    assign bus.win_valid = win_valid_r;
    assign bus.win_last  = win_last_r;

endmodule

// File: tb/tb_median_window.sv
// Directed bench for median_window: one instance with edge replication,
// one without. Windows are collected on the falling edge whenever an
// output transfer is about to occur and compared against hand-computed lists.
module tb_median_window;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [24:0] q0[$];
    logic [24:0] q1[$];

    median_window_if #(.DW(8)) b0 ();
    median_window_if #(.DW(8)) b1 ();

    median_window #(.DW(8), .EDGE_REPLICATE(1)) u_rep (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    median_window #(.DW(8), .EDGE_REPLICATE(0)) u_norep (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // record every window that transfers on the following rising edge
    always @(negedge clk) begin
        if (b0.win_valid && b0.win_ready) q0.push_back({b0.a0, b0.a1, b0.a2, b0.win_last});
        if (b1.win_valid && b1.win_ready) q1.push_back({b1.a0, b1.a1, b1.a2, b1.win_last});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive one sample and hold it until accepted (bounded wait)
    task automatic send(input int which, input logic [7:0] d, input logic l);
        logic ok;
        int   n;
        n = 0;
        if (which == 0) begin
            b0.in_data = d; b0.in_last = l; b0.in_valid = 1'b1;
        end else begin
            b1.in_data = d; b1.in_last = l; b1.in_valid = 1'b1;
        end
        do begin
            @(negedge clk);
            ok = (which == 0) ? b0.in_ready : b1.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) check("send_timeout", 32'(n), 32'd0);
    endtask

    task automatic idle(input int cycles);
        b0.in_valid = 1'b0;
        b1.in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic expect_win(input int which, input string tag,
                              input logic [7:0] x0, input logic [7:0] x1,
                              input logic [7:0] x2, input logic l);
        logic [24:0] got;
        got = 'x;
        if (which == 0 && q0.size() > 0) got = q0.pop_front();
        if (which == 1 && q1.size() > 0) got = q1.pop_front();
        check(tag, 32'(got), 32'({x0, x1, x2, l}));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        b0.in_data = 8'h00; b0.in_valid = 1'b0; b0.in_last = 1'b0; b0.win_ready = 1'b1;
        b1.in_data = 8'h00; b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.win_ready = 1'b1;

        // reset state
        #12;
        check("rst_in_ready", 32'(b0.in_ready), 32'd0);
        check("rst_win_valid", 32'(b0.win_valid), 32'd0);
        check("rst_win_last", 32'(b0.win_last), 32'd0);
        check("rst_a0a1a2", 32'({b0.a0, b0.a1, b0.a2}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready0", 32'(b0.in_ready), 32'd1);
        check("post_rst_in_ready1", 32'(b1.in_ready), 32'd1);

        // replicate mode, frame 1,2,3,4
        send(0, 8'd1, 1'b0); send(0, 8'd2, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd4, 1'b1);
        idle(5);
        expect_win(0, "f1234_w0", 8'd1, 8'd1, 8'd2, 1'b0);
        expect_win(0, "f1234_w1", 8'd1, 8'd2, 8'd3, 1'b0);
        expect_win(0, "f1234_w2", 8'd2, 8'd3, 8'd4, 1'b0);
        expect_win(0, "f1234_w3", 8'd3, 8'd4, 8'd4, 1'b1);
        check("f1234_count", 32'(q0.size()), 32'd0);

        // single-sample frame
        send(0, 8'h80, 1'b1);
        idle(4);
        expect_win(0, "single", 8'h80, 8'h80, 8'h80, 1'b1);
        check("single_count", 32'(q0.size()), 32'd0);

        // back-to-back frames with continuous valid
        send(0, 8'd1, 1'b0); send(0, 8'd2, 1'b1); send(0, 8'd3, 1'b0); send(0, 8'd4, 1'b1);
        idle(5);
        expect_win(0, "b2b_w0", 8'd1, 8'd1, 8'd2, 1'b0);
        expect_win(0, "b2b_w1", 8'd1, 8'd2, 8'd2, 1'b1);
        expect_win(0, "b2b_w2", 8'd3, 8'd3, 8'd4, 1'b0);
        expect_win(0, "b2b_w3", 8'd3, 8'd4, 8'd4, 1'b1);
        check("b2b_count", 32'(q0.size()), 32'd0);

        // backpressure: stall three cycles with window (1,2,3) in the slot
        send(0, 8'd1, 1'b0); send(0, 8'd2, 1'b0); send(0, 8'd3, 1'b0);
        b0.win_ready = 1'b0;
        b0.in_data = 8'd4; b0.in_last = 1'b0; b0.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(b0.in_ready), 32'd0);
            check("stall_valid", 32'(b0.win_valid), 32'd1);
            check("stall_hold", 32'({b0.a0, b0.a1, b0.a2, b0.win_last}),
                  32'({8'd1, 8'd2, 8'd3, 1'b0}));
        end
        @(posedge clk); #1;
        b0.win_ready = 1'b1;
        send(0, 8'd4, 1'b0); send(0, 8'd5, 1'b0); send(0, 8'd6, 1'b1);
        idle(5);
        expect_win(0, "bp_w0", 8'd1, 8'd1, 8'd2, 1'b0);
        expect_win(0, "bp_w1", 8'd1, 8'd2, 8'd3, 1'b0);
        expect_win(0, "bp_w2", 8'd2, 8'd3, 8'd4, 1'b0);
        expect_win(0, "bp_w3", 8'd3, 8'd4, 8'd5, 1'b0);
        expect_win(0, "bp_w4", 8'd4, 8'd5, 8'd6, 1'b0);
        expect_win(0, "bp_w5", 8'd5, 8'd6, 8'd6, 1'b1);
        check("bp_count", 32'(q0.size()), 32'd0);

        // reset while in RUN with a window held in the slot
        send(0, 8'd1, 1'b0); send(0, 8'd2, 1'b0); send(0, 8'd3, 1'b0);
        b0.win_ready = 1'b0;
        b0.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(b0.win_valid), 32'd0);
        check("arst_data", 32'({b0.a0, b0.a1, b0.a2, b0.win_last}), 32'd0);
        check("arst_in_ready", 32'(b0.in_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        b0.win_ready = 1'b1;
        q0.delete();
        q1.delete();
        send(0, 8'd9, 1'b0); send(0, 8'd9, 1'b1);
        idle(5);
        expect_win(0, "arst_w0", 8'd9, 8'd9, 8'd9, 1'b0);
        expect_win(0, "arst_w1", 8'd9, 8'd9, 8'd9, 1'b1);
        check("arst_count", 32'(q0.size()), 32'd0);

        // no replication: two-sample frame discarded, three-sample frame gives one window
        send(1, 8'd5, 1'b0); send(1, 8'd6, 1'b1);
        send(1, 8'd7, 1'b0); send(1, 8'd8, 1'b0); send(1, 8'd9, 1'b1);
        idle(4);
        expect_win(1, "norep_789", 8'd7, 8'd8, 8'd9, 1'b1);
        check("norep_count1", 32'(q1.size()), 32'd0);
        send(1, 8'd1, 1'b0); send(1, 8'd2, 1'b0); send(1, 8'd3, 1'b0); send(1, 8'd4, 1'b1);
        idle(4);
        expect_win(1, "norep_w0", 8'd1, 8'd2, 8'd3, 1'b0);
        expect_win(1, "norep_w1", 8'd2, 8'd3, 8'd4, 1'b1);
        check("norep_count2", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
